// File: rtl/alu_operand_sequencer.sv
// Four-phase ALU operand sequencer: drives the operand mux selects, lets the
// external muxes settle for a cycle, then captures one ALU result and its flags.
module alu_operand_sequencer #(
  parameter int SIZE = 8
) (
  input  logic            Clock,
  input  logic            Reset,
  input  logic            wStart,
  input  logic [2:0]      wOpcode,
  input  logic            wSelA,
  input  logic            wSelB,
  input  logic [SIZE-1:0] wOpA,
  input  logic [SIZE-1:0] wOpB,
  output logic            rMux_a_sel,
  output logic            rMux_b_sel,
  output logic [SIZE-1:0] rC,
  output logic            rCarry,
  output logic            rZero,
  output logic            rBusy,
  output logic            rDone
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SELECT  = 2'd1,
    EXECUTE = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_PASS = 3'b101;
  localparam logic [2:0] OP_SHL  = 3'b110;
  localparam logic [2:0] OP_SHR  = 3'b111;

  state_t          state_q;
  logic [2:0]      op_q;
  logic [SIZE:0]   alu_d;

  // Result packed as {flag, value}: the top bit is carry, borrow or shifted-out bit.
  function automatic logic [SIZE:0] alu_eval(input logic [2:0]      op,
                                             input logic [SIZE-1:0] a,
                                             input logic [SIZE-1:0] b);
    logic [SIZE:0] r;
    r = '0;
    case (op)
      OP_ADD:  r = {1'b0, a} + {1'b0, b};
      OP_SUB:  r = {1'b0, a} - {1'b0, b};
      OP_AND:  r = {1'b0, a & b};
      OP_OR:   r = {1'b0, a | b};
      OP_XOR:  r = {1'b0, a ^ b};
      OP_PASS: r = {1'b0, a};
      OP_SHL:  r = {a, 1'b0};
      OP_SHR:  r = {a[0], 1'b0, a[SIZE-1:1]};
      default: r = '0;
    endcase
    return r;
  endfunction

  always_comb begin
    alu_d = alu_eval(op_q, wOpA, wOpB);
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q    <= IDLE;
      op_q       <= '0;
      rMux_a_sel <= 1'b0;
      rMux_b_sel <= 1'b0;
      rC         <= '0;
      rCarry     <= 1'b0;
      rZero      <= 1'b0;
      rBusy      <= 1'b0;
      rDone      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (wStart) begin
            op_q       <= wOpcode;
            rMux_a_sel <= wSelA;
            rMux_b_sel <= wSelB;
            rBusy      <= 1'b1;
            state_q    <= SELECT;
          end
        end
        // Mux selects are now stable; operands are left to settle this cycle.
        SELECT: begin
          state_q <= EXECUTE;
        end
        EXECUTE: begin
          rC      <= alu_d[SIZE-1:0];
          rCarry  <= alu_d[SIZE];
          rZero   <= (alu_d[SIZE-1:0] == '0);
          rDone   <= 1'b1;
          state_q <= DONE;
        end
        DONE: begin
          rDone      <= 1'b0;
          rBusy      <= 1'b0;
          rMux_a_sel <= 1'b0;
          rMux_b_sel <= 1'b0;
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Directed bench for alu_operand_sequencer; models the two upstream 2:1 operand
// muxes whose feedback input is rC.
module tb_alu_operand_sequencer;

  logic       Clock = 1'b0;
  logic       Reset;
  logic       wStart;
  logic [2:0] wOpcode;
  logic       wSelA, wSelB;
  logic [7:0] a_ext, b_ext;
  logic [7:0] wOpA, wOpB;
  logic       rMux_a_sel, rMux_b_sel;
  logic [7:0] rC;
  logic       rCarry, rZero, rBusy, rDone;

  int checks   = 0;
  int failures = 0;

  always #5 Clock = ~Clock;

  assign wOpA = rMux_a_sel ? rC : a_ext;
  assign wOpB = rMux_b_sel ? rC : b_ext;

  alu_operand_sequencer #(.SIZE(8)) dut (
    .Clock(Clock), .Reset(Reset), .wStart(wStart), .wOpcode(wOpcode),
    .wSelA(wSelA), .wSelB(wSelB), .wOpA(wOpA), .wOpB(wOpB),
    .rMux_a_sel(rMux_a_sel), .rMux_b_sel(rMux_b_sel), .rC(rC),
    .rCarry(rCarry), .rZero(rZero), .rBusy(rBusy), .rDone(rDone)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full operation from a negedge in IDLE; inputs are scrambled after accept
  // so that anything not latched would corrupt the result.
  task automatic run_op(input string tag, input logic [2:0] op, input logic sa,
                        input logic sb, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] exp_c, input logic exp_cy, input logic exp_z);
    wOpcode = op; wSelA = sa; wSelB = sb; a_ext = a; b_ext = b; wStart = 1'b1;
    @(negedge Clock);
    wStart = 1'b0; wOpcode = ~op; wSelA = ~sa; wSelB = ~sb;
    chk({tag, "_sel_busy"}, {rBusy, rMux_a_sel, rMux_b_sel, rDone}, {1'b1, sa, sb, 1'b0});
    @(negedge Clock);
    chk({tag, "_exe"}, {rBusy, rMux_a_sel, rMux_b_sel, rDone}, {1'b1, sa, sb, 1'b0});
    @(negedge Clock);
    chk({tag, "_done"}, {rBusy, rMux_a_sel, rMux_b_sel, rDone}, {1'b1, sa, sb, 1'b1});
    chk({tag, "_rC"}, rC, exp_c);
    chk({tag, "_flags"}, {rCarry, rZero}, {exp_cy, exp_z});
    @(negedge Clock);
    chk({tag, "_idle"}, {rBusy, rMux_a_sel, rMux_b_sel, rDone}, 4'b0000);
  endtask

  initial begin
    Reset = 1'b0; wStart = 1'b0; wOpcode = 3'd0; wSelA = 1'b0; wSelB = 1'b0;
    a_ext = 8'h00; b_ext = 8'h00;

    // Reset state
    @(negedge Clock);
    chk("reset_outs", {rC, rCarry, rZero, rMux_a_sel, rMux_b_sel, rBusy, rDone}, '0);
    Reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge Clock);
      chk("idle_after_reset", {rC, rCarry, rZero, rMux_a_sel, rMux_b_sel, rBusy, rDone}, '0);
    end

    run_op("add_carry", 3'b000, 1'b0, 1'b0, 8'hF0, 8'h20, 8'h10, 1'b1, 1'b0);
    run_op("sub_fbA",   3'b001, 1'b1, 1'b0, 8'h55, 8'h10, 8'h00, 1'b0, 1'b1);
    run_op("sub_borrow",3'b001, 1'b0, 1'b0, 8'h01, 8'h02, 8'hFF, 1'b1, 1'b0);
    run_op("shr",       3'b111, 1'b0, 1'b0, 8'h01, 8'hAA, 8'h00, 1'b1, 1'b1);
    run_op("shl",       3'b110, 1'b0, 1'b0, 8'h81, 8'hAA, 8'h02, 1'b1, 1'b0);
    run_op("and",       3'b010, 1'b0, 1'b0, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0);
    run_op("or",        3'b011, 1'b0, 1'b0, 8'hF0, 8'h3C, 8'hFC, 1'b0, 1'b0);
    run_op("xor",       3'b100, 1'b0, 1'b0, 8'hF0, 8'h3C, 8'hCC, 1'b0, 1'b0);
    run_op("pass",      3'b101, 1'b0, 1'b0, 8'h5A, 8'hFF, 8'h5A, 1'b0, 1'b0);
    run_op("add_fbB",   3'b000, 1'b0, 1'b1, 8'h06, 8'h00, 8'h60, 1'b0, 1'b0);
    run_op("add_wrap",  3'b000, 1'b0, 1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1);
    run_op("shl_nocy",  3'b110, 1'b0, 1'b0, 8'h40, 8'h00, 8'h80, 1'b0, 1'b0);

    // Back-to-back starts with wStart held: rDone every 4 cycles
    wOpcode = 3'b000; wSelA = 1'b0; wSelB = 1'b0; a_ext = 8'h01; b_ext = 8'h01;
    wStart = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge Clock);
      chk($sformatf("b2b_done_%0d", i), rDone, (i == 2 || i == 6) ? 1'b1 : 1'b0);
    end
    wStart = 1'b0;
    @(negedge Clock);
    chk("b2b_rC", rC, 8'h02);
    @(negedge Clock);

    // Start pulse during EXECUTE with a different opcode is dropped
    begin
      int dones;
      dones = 0;
      wOpcode = 3'b000; a_ext = 8'hF0; b_ext = 8'h20; wStart = 1'b1;
      @(negedge Clock);
      wStart = 1'b0;
      @(negedge Clock);
      wOpcode = 3'b100; wStart = 1'b1;
      for (int i = 0; i < 8; i++) begin
        @(negedge Clock);
        wStart = 1'b0;
        if (rDone) dones++;
      end
      chk("ignore_start_dones", dones, 1);
      chk("ignore_start_rC", rC, 8'h10);
      chk("ignore_start_busy", rBusy, 1'b0);
    end

    // Reset during EXECUTE aborts the operation
    wOpcode = 3'b010; a_ext = 8'hFF; b_ext = 8'hFF; wStart = 1'b1;
    @(negedge Clock);
    wStart = 1'b0;
    @(negedge Clock);
    chk("pre_abort_rC", rC, 8'h10);
    Reset = 1'b0;
    #1;
    chk("abort_async", {rC, rBusy, rDone, rMux_a_sel, rMux_b_sel}, '0);
    @(negedge Clock);
    Reset = 1'b1;
    begin
      int dones;
      dones = 0;
      for (int i = 0; i < 5; i++) begin
        @(negedge Clock);
        if (rDone) dones++;
      end
      chk("abort_no_done", dones, 0);
      chk("abort_rC", {rC, rBusy}, '0);
    end
    run_op("after_abort", 3'b000, 1'b0, 1'b0, 8'h01, 8'h02, 8'h03, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
